// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, signed or unsigned, with valid/ready handshakes.
// It retires K bits of A per clock, so a product takes N/K cycles in BUSY.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands A, B and sgn are presented
//   in_ready   block can accept operands (high only in IDLE)
//   A          multiplier operand, N bits
//   B          multiplicand operand, M bits
//   sgn        1 = two's-complement operands, 0 = unsigned; sampled with the operands
//   out_valid  O holds a completed product (high only in DONE)
//   out_ready  consumer accepts O
//   O          product, N+M bits; held until the next product completes
module seq_mult #(
    parameter int unsigned N = 8,
    parameter int unsigned M = N,
    parameter int unsigned K = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [M-1:0]     B,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   O
);

    localparam int unsigned W     = N + M;
    localparam int unsigned STEPS = N / K;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    a_sh;     // remaining digits of A, current digit in the low K bits
    logic [W-1:0]    b_sh;     // extended B, pre-shifted to the current digit position
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_nxt;
    logic [CW-1:0]   cnt;
    logic            sgn_r;
    logic            last_c;
    logic [K-1:0]    digit;

    // The final step carries bit N-1 of A, which has negative weight in signed mode.
    assign last_c = (cnt == CW'(1));

    // Accumulate one K-bit digit: each set bit adds B shifted by its position.
    always_comb begin
        acc_nxt = acc;
        digit   = a_sh[K-1:0];
        for (int unsigned i = 0; i < K; i++) begin
            if (digit[0]) begin
                if (sgn_r && last_c && (i == K - 1)) begin
                    acc_nxt = acc_nxt - (b_sh << i);
                end else begin
                    acc_nxt = acc_nxt + (b_sh << i);
                end
            end
            digit = digit >> 1;
        end
    end

    // Control FSM and datapath registers; in_ready/out_valid are registered state decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            O         <= '0;
            acc       <= '0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sgn_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= A;
                        b_sh     <= {{N{sgn & B[M-1]}}, B};
                        sgn_r    <= sgn;
                        acc      <= '0;
                        cnt      <= CW'(STEPS);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh >> K;
                    b_sh <= b_sh << K;
                    cnt  <= cnt - CW'(1);
                    if (last_c) begin
                        O         <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
